// File: rtl/irq_controller.sv
// Interrupt front-end: synchronises IRQ/NMI pins, masks, arbitrates by fixed
// priority and hands one request at a time to the control unit.
module irq_controller #(
  parameter int          NUM_IRQ     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'hFFE0,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic               nmi_n,
  input  logic               i_flag,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               int_req,
  output logic               int_is_nmi,
  output logic [3:0]         int_chan,
  output logic [15:0]        vector,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0]     irq_sq [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] nmi_sq;
  logic                   nmi_prev;
  logic                   nmi_latch;
  logic [NUM_IRQ-1:0]     mask_q;
  logic                   nmi_q;
  logic [3:0]             chan_q;
  logic [15:0]            vec_q;

  logic                   nmi_fall;
  logic [3:0]             win_chan;
  logic                   win_hit;
  logic                   irq_elig;
  logic                   have_src;
  logic                   take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        irq_sq[i] <= '1;
      nmi_sq   <= '1;
      nmi_prev <= 1'b1;
    end else begin
      irq_sq[0] <= irq_n;
      for (int i = 1; i < SYNC_STAGES; i++)
        irq_sq[i] <= irq_sq[i-1];
      nmi_sq   <= {nmi_sq[SYNC_STAGES-2:0], nmi_n};
      nmi_prev <= nmi_sq[SYNC_STAGES-1];
    end
  end

  assign nmi_fall = nmi_prev & ~nmi_sq[SYNC_STAGES-1];
  assign pending  = ~irq_sq[SYNC_STAGES-1] & mask_q;

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win_chan = '0;
    win_hit  = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_chan = 4'(i);
        win_hit  = 1'b1;
      end
    end
  end

  assign irq_elig = win_hit & ~i_flag;
  assign have_src = nmi_latch | irq_elig;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (have_src)
          state_d = REQ;
      end
      REQ: begin
        if (!have_src) begin
          state_d = IDLE;
        end else if (int_ack) begin
          take    = 1'b1;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (int_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mask_q    <= '1;
      nmi_latch <= 1'b0;
      nmi_q     <= 1'b0;
      chan_q    <= '0;
      vec_q     <= '0;
    end else begin
      state_q <= state_d;
      if (mask_wr)
        mask_q <= mask_data;
      // A new edge in the same cycle as an NMI ack re-arms the latch.
      nmi_latch <= (nmi_latch & ~(take & nmi_latch)) | nmi_fall;
      if (take) begin
        nmi_q <= nmi_latch;
        if (nmi_latch) begin
          chan_q <= '0;
          vec_q  <= NMI_VEC;
        end else begin
          chan_q <= win_chan;
          vec_q  <= VEC_BASE + {11'b0, win_chan, 1'b0};
        end
      end
    end
  end

  assign int_req  = (state_q == REQ);
  assign int_chan = chan_q;
  assign vector   = vec_q;

  always_comb begin
    int_is_nmi = 1'b0;
    unique case (state_q)
      REQ:     int_is_nmi = nmi_latch;
      SERVICE: int_is_nmi = nmi_q;
      default: int_is_nmi = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_irq_controller;

  localparam int S = 2;
  localparam int N = 8;
  localparam int VB = 16'hFFE0;
  localparam int NV = 16'hFFFA;

  logic         clk;
  logic         rst;
  logic [N-1:0] irq_n;
  logic         nmi_n;
  logic         i_flag;
  logic         mask_wr;
  logic [N-1:0] mask_data;
  logic         int_ack;
  logic         int_done;
  logic         int_req;
  logic         int_is_nmi;
  logic [3:0]   int_chan;
  logic [15:0]  vector;
  logic [N-1:0] pending;

  irq_controller #(
    .NUM_IRQ(N),
    .SYNC_STAGES(S),
    .VEC_BASE(16'hFFE0),
    .NMI_VEC(16'hFFFA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq_n(irq_n),
    .nmi_n(nmi_n),
    .i_flag(i_flag),
    .mask_wr(mask_wr),
    .mask_data(mask_data),
    .int_ack(int_ack),
    .int_done(int_done),
    .int_req(int_req),
    .int_is_nmi(int_is_nmi),
    .int_chan(int_chan),
    .vector(vector),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // Reference model: pins seen through an S-deep delay, service phase 0/1/2.
  logic [N-1:0] q_irq[$];
  logic         q_nmi[$];
  logic         m_prev;
  int           m_nmi_events;
  logic [N-1:0] m_mask;
  int           m_phase;
  int           m_cnmi;
  int           m_chan;
  int           m_vec;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q_irq.delete();
    q_nmi.delete();
    repeat (S) begin
      q_irq.push_front('1);
      q_nmi.push_front(1'b1);
    end
    m_prev       = 1'b1;
    m_nmi_events = 0;
    m_mask       = '1;
    m_phase      = 0;
    m_cnmi       = 0;
    m_chan       = 0;
    m_vec        = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] pend;
    bit elig, src, fall, clr;
    pend = ~q_irq[$] & m_mask;
    elig = (pend != 0) && !i_flag;
    src  = (m_nmi_events > 0) || elig;
    fall = m_prev && !q_nmi[$];
    clr  = 0;
    case (m_phase)
      0: if (src) m_phase = 1;
      1: begin
        if (!src) m_phase = 0;
        else if (int_ack) begin
          if (m_nmi_events > 0) begin
            m_cnmi = 1; m_chan = 0; m_vec = NV; clr = 1;
          end else begin
            m_cnmi = 0;
            m_chan = lowest(pend);
            m_vec  = (VB + 2 * m_chan) % 65536;
          end
          m_phase = 2;
        end
      end
      default: if (int_done) m_phase = 0;
    endcase
    if (clr) m_nmi_events = 0;
    if (fall) m_nmi_events = 1;
    m_prev = q_nmi[$];
    q_irq.push_front(irq_n);
    void'(q_irq.pop_back());
    q_nmi.push_front(nmi_n);
    void'(q_nmi.pop_back());
    if (mask_wr) m_mask = mask_data;
  endtask

  task automatic compare();
    int exp_nmi;
    exp_nmi = (m_phase == 1) ? int'(m_nmi_events > 0) :
              (m_phase == 2) ? m_cnmi : 0;
    chk("req", 32'(int_req), 32'(m_phase == 1));
    chk("is_nmi", 32'(int_is_nmi), 32'(exp_nmi));
    chk("chan", 32'(int_chan), 32'(m_chan));
    chk("vector", 32'(vector), 32'(m_vec));
    chk("pending", 32'(pending), 32'(~q_irq[$] & m_mask));
  endtask

  task automatic step(input logic [N-1:0] irq, input logic nmi,
                      input logic ifl, input logic mwr,
                      input logic [N-1:0] mdat, input logic ack,
                      input logic done);
    irq_n     = irq;
    nmi_n     = nmi;
    i_flag    = ifl;
    mask_wr   = mwr;
    mask_data = mdat;
    int_ack   = ack;
    int_done  = done;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) step('1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(int_req), 32'h0);
    chk("rst_nmi", 32'(int_is_nmi), 32'h0);
    chk("rst_chan", 32'(int_chan), 32'h0);
    chk("rst_vec", 32'(vector), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    model_reset();
    irq_n = '1; nmi_n = 1'b1; i_flag = 1'b0; mask_wr = 1'b0;
    int_ack = 1'b0; int_done = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r_irq;
    logic         r_nmi;
    int           n;
    n_vec = 0;
    n_bad = 0;
    irq_n = '1; nmi_n = 1'b1; i_flag = 1'b0; mask_wr = 1'b0;
    mask_data = '0; int_ack = 1'b0; int_done = 1'b0;
    rst = 1'b1;
    model_reset();
    #3;
    pulse_reset();
    idle(3);

    // IRQ3: request latency and vector
    n = 0;
    do begin
      step(~8'h08, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      n++;
    end while (!int_req && n < 10);
    chk("t1_latency", 32'(n), 32'(S + 1));
    step(~8'h08, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t1_vec", 32'(vector), 32'hFFE6);
    chk("t1_chan", 32'(int_chan), 32'd3);
    step('1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(4);

    // i_flag withdrawal while requesting
    repeat (S + 1) step(~8'h01, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("t3_req", 32'(int_req), 32'h1);
    step(~8'h01, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t3_drop", 32'(int_req), 32'h0);
    chk("t3_vec", 32'(vector), 32'hFFE6);
    idle(4);

    // Masked channel 0, then channel 1
    step('1, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    repeat (S + 2) step(~8'h01, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("t4_pend", 32'(pending), 32'h0);
    chk("t4_noreq", 32'(int_req), 32'h0);
    repeat (S + 1) step(~8'h03, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(~8'h03, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t4_vec", 32'(vector), 32'hFFE2);

    // Reset mid-service; mask must return to all ones
    #3;
    pulse_reset();
    repeat (S) step(8'h00, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("t6_mask", 32'(pending), 32'hFF);
    idle(4);

    r_irq = '1;
    r_nmi = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0)
        r_irq = ~N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0)
        r_nmi = ~r_nmi;
      step(r_irq, r_nmi, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 19) == 0), N'($urandom | $urandom),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
